key_matrix_scanner: RTL and testbench

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

---
 rtl/key_matrix_scanner.sv | 161 ++++++++++++++++
 tb/tb_key_matrix_scanner.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: column-scanning 8x8 active-low key matrix reader with a 2-flop row synchronizer.
// Define KEY_DEBOUNCE_EN to add a per-key 3-commit debounce filter on the published key map.
module key_matrix_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic        scanEn,
    input  logic        timePulseIn,
    input  logic [7:0]  rowIn,
    output logic [7:0]  colOut,
    output logic [63:0] matrixOut,
    output logic        frameValid,
    output logic        keyEvent,
    output logic        anyKey
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, NEXT, COMMIT} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [2:0]  r_index;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic [63:0] r_shadow;
    logic [63:0] r_matrix;
    logic [63:0] w_nextMatrix;
    logic [63:0] w_shadowSampled;
    logic        r_frameValid;
    logic        r_keyEvent;
    logic        r_anyKey;
    logic        w_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 8'hFF;
            r_sync2 <= 8'hFF;
        end else begin
            r_sync1 <= rowIn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign w_abort = !scanEn && (r_state == DRIVE || r_state == SETTLE ||
                                 r_state == SAMPLE || r_state == NEXT);

    // The active column stays driven from DRIVE through NEXT so sampling sees a stable column.
    always_comb begin
        w_nextState = r_state;
        colOut      = 8'hFF;
        case (r_state)
            IDLE: begin
                if (scanEn) w_nextState = DRIVE;
            end
            DRIVE: begin
                colOut      = ~(8'h80 >> r_index);
                w_nextState = scanEn ? SETTLE : IDLE;
            end
            SETTLE: begin
                colOut = ~(8'h80 >> r_index);
                if (!scanEn)          w_nextState = IDLE;
                else if (timePulseIn) w_nextState = SAMPLE;
            end
            SAMPLE: begin
                colOut      = ~(8'h80 >> r_index);
                w_nextState = scanEn ? NEXT : IDLE;
            end
            NEXT: begin
                colOut = ~(8'h80 >> r_index);
                if (!scanEn)               w_nextState = IDLE;
                else if (r_index == 3'd7)  w_nextState = COMMIT;
                else                       w_nextState = DRIVE;
            end
            COMMIT: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_index <= 3'd0;
        end else if (r_state == IDLE || w_abort) begin
            r_index <= 3'd0;
        end else if (r_state == NEXT && r_index != 3'd7) begin
            r_index <= r_index + 3'd1;
        end
    end

    // Row k of the sync'd bus lands in byte k; column index i maps to bit 7-i (= ~i) of that byte.
    always_comb begin
        w_shadowSampled = r_shadow;
        for (int k = 0; k < 8; k++) begin
            w_shadowSampled[{3'(k), ~r_index}] = ~r_sync2[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
        end else if (w_abort) begin
            r_shadow <= '0;
        end else if (r_state == SAMPLE) begin
            r_shadow <= w_shadowSampled;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    logic [1:0] r_debCnt [64];
    logic [1:0] w_nextCnt [64];

    // A key flips only after three consecutive commits disagree with the published value.
    always_comb begin
        w_nextMatrix = r_matrix;
        for (int k = 0; k < 64; k++) begin
            w_nextCnt[k] = 2'd0;
            if (r_shadow[k] != r_matrix[k]) begin
                if (r_debCnt[k] == 2'd2) w_nextMatrix[k] = ~r_matrix[k];
                else                     w_nextCnt[k]    = r_debCnt[k] + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 64; k++) r_debCnt[k] <= 2'd0;
        end else if (r_state == COMMIT) begin
            r_debCnt <= w_nextCnt;
        end
    end
`else
    assign w_nextMatrix = r_shadow;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_matrix     <= '0;
            r_frameValid <= 1'b0;
            r_keyEvent   <= 1'b0;
            r_anyKey     <= 1'b0;
        end else begin
            r_frameValid <= (r_state == COMMIT);
            r_keyEvent   <= (r_state == COMMIT) && (w_nextMatrix != r_matrix);
            if (r_state == COMMIT) r_matrix <= w_nextMatrix;
            r_anyKey     <= |r_matrix;
        end
    end

    assign matrixOut  = r_matrix;
    assign frameValid = r_frameValid;
    assign keyEvent   = r_keyEvent;
    assign anyKey     = r_anyKey;
endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: randomized bench for key_matrix_scanner against a frame-level key map model.
// Build with KEY_DEBOUNCE_EN to switch the model and add the debounce scenario.
module tb_key_matrix_scanner;
    logic        clk = 1'b0;
    logic        rst;
    logic        scanEn;
    logic        timePulseIn;
    logic [7:0]  rowIn;
    logic [7:0]  colOut;
    logic [63:0] matrixOut;
    logic        frameValid;
    logic        keyEvent;
    logic        anyKey;

    key_matrix_scanner dut (
        .clk(clk), .rst(rst), .scanEn(scanEn), .timePulseIn(timePulseIn),
        .rowIn(rowIn), .colOut(colOut), .matrixOut(matrixOut),
        .frameValid(frameValid), .keyEvent(keyEvent), .anyKey(anyKey)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [1:8][1:8] keys;
    logic [1:8][1:8] expKeys;
`ifdef KEY_DEBOUNCE_EN
    int debCount [1:8][1:8];
`endif

    int  pulseMode = 0;
    int  pulseCtr = 0;
    logic [7:0] colSeq[$];
    int  frameCycles;
    bit  timedOut;
    logic [63:0] obsMatrix;
    logic obsEvent, obsAnyNext, obsFvNext;
    time lastFv = 0;
    time prevFv = 0;

    // Physical matrix: a pressed key pulls its row low whenever its column is driven low.
    always_comb begin
        rowIn = 8'hFF;
        for (int r = 1; r <= 8; r++)
            for (int c = 1; c <= 8; c++)
                if (keys[r][c] && colOut[8-c] == 1'b0) rowIn[8-r] = 1'b0;
    end

    function automatic logic [63:0] packKeys(input logic [1:8][1:8] k);
        logic [63:0] m = '0;
        for (int r = 1; r <= 8; r++)
            for (int c = 1; c <= 8; c++)
                m[72 - 8*r - c] = k[r][c];
        return m;
    endfunction

    task automatic modelReset();
        expKeys = '0;
`ifdef KEY_DEBOUNCE_EN
        for (int r = 1; r <= 8; r++)
            for (int c = 1; c <= 8; c++) debCount[r][c] = 0;
`endif
    endtask

    task automatic modelCommit(output bit changed);
        changed = 0;
        for (int r = 1; r <= 8; r++) begin
            for (int c = 1; c <= 8; c++) begin
`ifdef KEY_DEBOUNCE_EN
                if (keys[r][c] == expKeys[r][c]) begin
                    debCount[r][c] = 0;
                end else begin
                    debCount[r][c]++;
                    if (debCount[r][c] == 3) begin
                        expKeys[r][c]  = keys[r][c];
                        debCount[r][c] = 0;
                        changed = 1;
                    end
                end
`else
                if (expKeys[r][c] != keys[r][c]) changed = 1;
                expKeys[r][c] = keys[r][c];
`endif
            end
        end
    endtask

    task automatic randomKeys(input int density);
        for (int r = 1; r <= 8; r++)
            for (int c = 1; c <= 8; c++)
                keys[r][c] = ($urandom_range(0, 99) < density);
    endtask

    task automatic drivePulse();
        pulseCtr++;
        case (pulseMode)
            0:       timePulseIn = 1'b1;
            1:       timePulseIn = (pulseCtr % 4 == 0);
            2:       timePulseIn = ($urandom_range(0, 2) == 0);
            default: timePulseIn = 1'b0;
        endcase
    endtask

    // Runs until the next frameValid, collecting the colOut sequence and the commit outputs.
    task automatic runFrame();
        logic [7:0] lastCol = 8'hFF;
        colSeq.delete();
        timedOut    = 1'b0;
        frameCycles = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            frameCycles++;
            if (colOut !== lastCol) begin
                colSeq.push_back(colOut);
                lastCol = colOut;
            end
            if (frameValid === 1'b1) begin
                obsMatrix = matrixOut;
                obsEvent  = keyEvent;
                prevFv    = lastFv;
                lastFv    = $time;
                drivePulse();
                @(negedge clk);
                obsAnyNext = anyKey;
                obsFvNext  = frameValid;
                drivePulse();
                return;
            end
            drivePulse();
        end
        timedOut = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        scanEn = 1'b0;
        timePulseIn = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; scanEn = 1'b0; timePulseIn = 1'b0; keys = '0;
        modelReset();
        repeat (3) @(negedge clk);
        vectors++;
        if (colOut !== 8'hFF) begin miscompares++; $display("[TB] FAIL reset_colOut: got %h expected ff", colOut); end
        vectors++;
        if (matrixOut !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_matrix: got %h expected 0", matrixOut); end
        vectors++;
        if (frameValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frameValid: got %b expected 0", frameValid); end
        vectors++;
        if (keyEvent !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_keyEvent: got %b expected 0", keyEvent); end
        vectors++;
        if (anyKey !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_anyKey: got %b expected 0", anyKey); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_key();
        bit ev;
        bit seqOk;
        logic [7:0] expSeq[$];
        logic [7:0] v;
        keys = '0;
        keys[3][5] = 1'b1;
        pulseMode = 1;
        scanEn = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            v = 8'hFF;
            v[8-c] = 1'b0;
            expSeq.push_back(v);
        end
        expSeq.push_back(8'hFF);
        for (int f = 0; f < 2; f++) begin
            runFrame();
            modelCommit(ev);
            vectors++;
            if (timedOut) begin miscompares++; $display("[TB] FAIL single_frame_timeout: got no frameValid expected one"); end
            vectors++;
            if (obsMatrix !== packKeys(expKeys)) begin miscompares++; $display("[TB] FAIL single_matrix: got %h expected %h", obsMatrix, packKeys(expKeys)); end
`ifndef KEY_DEBOUNCE_EN
            vectors++;
            if (obsMatrix !== 64'h0000_0800_0000_0000) begin miscompares++; $display("[TB] FAIL single_matrix_r3c5: got %h expected 0000080000000000", obsMatrix); end
`endif
            vectors++;
            if (obsEvent !== ev) begin miscompares++; $display("[TB] FAIL single_keyEvent: got %b expected %b", obsEvent, ev); end
            vectors++;
            if (obsAnyNext !== (|packKeys(expKeys))) begin miscompares++; $display("[TB] FAIL single_anyKey: got %b expected %b", obsAnyNext, |packKeys(expKeys)); end
            vectors++;
            if (obsFvNext !== 1'b0) begin miscompares++; $display("[TB] FAIL single_fv_pulse: got %b expected 0", obsFvNext); end
            seqOk = (colSeq.size() == expSeq.size());
            for (int i = 0; i < colSeq.size() && seqOk; i++)
                if (colSeq[i] !== expSeq[i]) seqOk = 0;
            vectors++;
            if (!seqOk) begin miscompares++; $display("[TB] FAIL single_colSeq: got %0d values (first %h) expected 9 values starting 7f", colSeq.size(), colSeq.size() > 0 ? colSeq[0] : 8'h00); end
        end
    endtask

    task automatic test_frame_length();
        bit ev;
        pulseMode = 0;
        timePulseIn = 1'b1;
        for (int f = 0; f < 3; f++) begin
            randomKeys(30);
            runFrame();
            modelCommit(ev);
            vectors++;
            if (obsMatrix !== packKeys(expKeys)) begin miscompares++; $display("[TB] FAIL len_matrix: got %h expected %h", obsMatrix, packKeys(expKeys)); end
            if (f > 0) begin
                vectors++;
                if ((lastFv - prevFv) / 10 != 34) begin miscompares++; $display("[TB] FAIL len_cycles: got %0d expected 34", (lastFv - prevFv) / 10); end
            end
        end
    endtask

    task automatic test_abort();
        bit ev;
        bit found = 0;
        int fvSeen = 0;
        pulseMode = 1;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (colOut === 8'hEF) found = 1;
            else drivePulse();
        end
        vectors++;
        if (!found) begin miscompares++; $display("[TB] FAIL abort_reach_col4: got no ef expected ef"); end
        pulseMode = 3;
        timePulseIn = 1'b0;
        @(negedge clk);
        scanEn = 1'b0;
        @(negedge clk);
        vectors++;
        if (colOut !== 8'hFF) begin miscompares++; $display("[TB] FAIL abort_colOut: got %h expected ff", colOut); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frameValid === 1'b1) fvSeen++;
        end
        vectors++;
        if (fvSeen != 0) begin miscompares++; $display("[TB] FAIL abort_frameValid: got %0d pulses expected 0", fvSeen); end
        vectors++;
        if (matrixOut !== packKeys(expKeys)) begin miscompares++; $display("[TB] FAIL abort_matrix_kept: got %h expected %h", matrixOut, packKeys(expKeys)); end
        randomKeys(40);
        scanEn = 1'b1;
        pulseMode = 1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (colOut !== 8'hFF) found = 1;
            drivePulse();
        end
        vectors++;
        if (colOut !== 8'h7F) begin miscompares++; $display("[TB] FAIL abort_restart_col: got %h expected 7f", colOut); end
        runFrame();
        modelCommit(ev);
        vectors++;
        if (obsMatrix !== packKeys(expKeys)) begin miscompares++; $display("[TB] FAIL abort_next_matrix: got %h expected %h", obsMatrix, packKeys(expKeys)); end
    endtask

    task automatic test_random();
        bit ev;
        pulseMode = 2;
        for (int f = 0; f < 8; f++) begin
            if (f == 0)      randomKeys(100);
            else if (f == 1) randomKeys(0);
            else             randomKeys(25);
            runFrame();
            modelCommit(ev);
            vectors++;
            if (timedOut) begin miscompares++; $display("[TB] FAIL rand_timeout: got no frameValid expected one"); end
            vectors++;
            if (obsMatrix !== packKeys(expKeys)) begin miscompares++; $display("[TB] FAIL rand_matrix: got %h expected %h", obsMatrix, packKeys(expKeys)); end
            vectors++;
            if (obsEvent !== ev) begin miscompares++; $display("[TB] FAIL rand_keyEvent: got %b expected %b", obsEvent, ev); end
            vectors++;
            if (obsAnyNext !== (|packKeys(expKeys))) begin miscompares++; $display("[TB] FAIL rand_anyKey: got %b expected %b", obsAnyNext, |packKeys(expKeys)); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ev;
        bit found = 0;
        randomKeys(50);
        keys[1][1] = 1'b1;
        pulseMode = 1;
        runFrame();
        modelCommit(ev);
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (colOut === 8'hF7) found = 1;
            else drivePulse();
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (colOut !== 8'hFF) begin miscompares++; $display("[TB] FAIL midrst_colOut: got %h expected ff", colOut); end
        vectors++;
        if (matrixOut !== 64'h0) begin miscompares++; $display("[TB] FAIL midrst_matrix: got %h expected 0", matrixOut); end
        vectors++;
        if ({frameValid, keyEvent, anyKey} !== 3'b000) begin miscompares++; $display("[TB] FAIL midrst_flags: got %b expected 000", {frameValid, keyEvent, anyKey}); end
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (colOut !== 8'hFF) found = 1;
            drivePulse();
        end
        vectors++;
        if (colOut !== 8'h7F) begin miscompares++; $display("[TB] FAIL midrst_restart_col: got %h expected 7f", colOut); end
        runFrame();
        modelCommit(ev);
        vectors++;
        if (obsMatrix !== packKeys(expKeys)) begin miscompares++; $display("[TB] FAIL midrst_matrix_after: got %h expected %h", obsMatrix, packKeys(expKeys)); end
    endtask

`ifdef KEY_DEBOUNCE_EN
    task automatic test_debounce();
        bit ev;
        bit pattern [7] = '{1, 1, 0, 1, 1, 1, 1};
        doReset();
        keys = '0;
        scanEn = 1'b1;
        pulseMode = 1;
        for (int f = 0; f < 7; f++) begin
            keys[8][8] = pattern[f];
            runFrame();
            modelCommit(ev);
            vectors++;
            if (obsMatrix[0] !== expKeys[8][8]) begin miscompares++; $display("[TB] FAIL deb_bit0 commit %0d: got %b expected %b", f + 1, obsMatrix[0], expKeys[8][8]); end
            vectors++;
            if (obsEvent !== ev) begin miscompares++; $display("[TB] FAIL deb_keyEvent commit %0d: got %b expected %b", f + 1, obsEvent, ev); end
        end
    endtask
`endif

    initial begin
        keys = '0;
        test_reset();
        test_single_key();
        test_frame_length();
        test_abort();
        test_random();
        test_reset_midframe();
`ifdef KEY_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
